op_slot_sequencer: RTL and testbench
====================================

Name: op_slot_sequencer

Overview:
- Parametrised time-slot sequencer for the FM operator datapath; the successor to the fixed 2-bank x 18-operator sequencer.
- On each sample tick it walks every (bank, operator) slot and issues one enable per slot to the shared operator core.
- It re-tags the core's delayed result with bank and operator number, and holds the last result for modulation.
- New behaviour: a per-slot skip mask (skipped slots cost one cycle), a frame-done pulse and sticky overrun detection.

Parameters:
- NUM_BANKS, 2, number of register banks; BANK_W = max(1, $clog2(NUM_BANKS)).
- OPS_PER_BANK, 18, operators per bank; OP_W = $clog2(OPS_PER_BANK).
- SLOT_CYCLES, 2, clock cycles per issued slot (>=1); the gap between successive op_en pulses.
- PIPELINE_DELAY, 6, cycles from op_en to valid op_data_in (>=1).
- OP_OUT_WIDTH, 13, signed operator result width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- sample_clk_en  in  1  single-cycle frame start tick
- skip_mask  in  NUM_BANKS*OPS_PER_BANK  bit b*OPS_PER_BANK+o set = skip slot (b,o); sampled at frame start
- op_en  out  1  operator core enable, one cycle per issued slot
- op_bank  out  BANK_W  bank of current slot
- op_num  out  OP_W  operator of current slot
- op_data_in  in  OP_OUT_WIDTH  signed core result, valid PIPELINE_DELAY cycles after op_en
- out_valid  out  1  tagged result valid
- out_bank  out  BANK_W  bank tag of result
- out_op  out  OP_W  operator tag of result
- out_data  out  OP_OUT_WIDTH  signed result
- mod_prev  out  OP_OUT_WIDTH  last captured result, held between captures
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle end-of-frame pulse
- overrun  out  1  sticky: a tick arrived while busy
- overrun_clr  in  1  clears overrun

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; result pipeline flushed. Reset mid-frame abandons the frame; no frame_done is produced.
- States:
  - IDLE: when sample_clk_en=1, latch skip_mask, set slot=0, go to ISSUE.
  - ISSUE, one cycle per slot:
    - Unskipped slot: op_en=1. If SLOT_CYCLES>1, go to WAIT for SLOT_CYCLES-1 cycles, else advance.
    - Skipped slot: op_en=0 and advance next cycle (1 cycle total).
    - After the last slot, go to DRAIN.
  - DRAIN: wait until the result pipeline and out register are empty. Then assert frame_done for one cycle and return to IDLE.
- Slot order is bank-major: bank 0 ops 0..OPS_PER_BANK-1, then bank 1, and so on. op_bank/op_num are held constant for the whole slot, including WAIT.
- Tag pipeline: {valid, bank, op} shift register, PIPELINE_DELAY deep, fed by op_en. When its tap is valid, op_data_in is captured. On the next edge: out_valid=1, out_bank/out_op = tag, out_data = op_data_in, mod_prev = op_data_in.
- Latency: out_valid is asserted PIPELINE_DELAY+1 cycles after op_en. out_valid is cleared when the tap is invalid; out_data and mod_prev hold their values.
- frame_done is asserted the cycle after the final out_valid. If every slot is skipped, it is asserted the cycle after entering DRAIN.
- busy=1 in ISSUE, WAIT and DRAIN, including the frame_done cycle. busy=0 only in IDLE.
- sample_clk_en while busy: ignored and the frame continues; overrun is set on the next edge. If set and overrun_clr occur in the same cycle, set wins.
- skip_mask changes mid-frame have no effect until the next frame.
- Frame length with no skips: NUM_BANKS*OPS_PER_BANK*SLOT_CYCLES issue cycles, plus the drain.

Test Plan:
- Defaults, mask=0, tick at cycle 0:
  - op_en at cycles 1,3,...,71 with (bank,op) = (0,0)..(1,17).
  - out_valid at 8,10,...,78; frame_done at 79; busy 1 for cycles 1..79, 0 at 80.
- Defaults, mask = all ones except bit 35, tick at 0:
  - Single op_en at cycle 36.
  - out_valid at 43 with out_bank=1, out_op=17; frame_done at 44.
- op_data_in = -5 (0x1FFB) at op_en+6 for slot (0,3) -> out_data = -5 and mod_prev = -5 one cycle later; mod_prev holds -5 until the next capture.
- Overrun:
  - Second tick at cycle 20 -> overrun=1 from cycle 21, frame timing unchanged.
  - overrun_clr alone -> overrun=0.
  - overrun_clr plus a tick while busy in the same cycle -> stays 1.
- reset_n low at cycle 30 -> outputs 0 immediately, no frame_done. A tick after release restarts at slot (0,0).
- NUM_BANKS=1, OPS_PER_BANK=4, SLOT_CYCLES=3, PIPELINE_DELAY=2, tick at 0:
  - op_en at 1,4,7,10; out_valid at 4,7,10,13; frame_done at 14.

Source files
------------

// File: rtl/op_slot_sequencer.sv
// Purpose : time-slot sequencer for the FM operator core; walks every (bank, op) slot per sample tick,
//           re-tags delayed core results and keeps the last result for modulation.
// Latency : out_valid follows op_en by PIPELINE_DELAY+1 cycles; frame_done one cycle after the last result.
// Backpressure: none -- the operator core accepts one op_en per slot; ticks arriving while busy are dropped
//           and flagged in the sticky overrun bit.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   sample_clk_en        frame start tick (single cycle)
//   skip_mask            per-slot skip bits, bit b*OPS_PER_BANK+o skips slot (b,o); latched at frame start
//   op_en/op_bank/op_num operator core enable and current slot coordinates
//   op_data_in           signed core result, valid PIPELINE_DELAY cycles after op_en
//   out_valid/out_bank/out_op/out_data  tagged result
//   mod_prev             last captured result, held between captures
//   busy, frame_done     frame in progress / one-cycle end-of-frame pulse
//   overrun, overrun_clr sticky "tick while busy" flag and its clear

module op_slot_sequencer #(
  parameter int NUM_BANKS      = 2,
  parameter int OPS_PER_BANK   = 18,
  parameter int SLOT_CYCLES    = 2,
  parameter int PIPELINE_DELAY = 6,
  parameter int OP_OUT_WIDTH   = 13,
  localparam int BANK_W        = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int OP_W          = (OPS_PER_BANK > 1) ? $clog2(OPS_PER_BANK) : 1,
  localparam int NUM_SLOTS     = NUM_BANKS * OPS_PER_BANK
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           sample_clk_en,
  input  logic [NUM_SLOTS-1:0]           skip_mask,
  output logic                           op_en,
  output logic [BANK_W-1:0]              op_bank,
  output logic [OP_W-1:0]                op_num,
  input  logic signed [OP_OUT_WIDTH-1:0] op_data_in,
  output logic                           out_valid,
  output logic [BANK_W-1:0]              out_bank,
  output logic [OP_W-1:0]                out_op,
  output logic signed [OP_OUT_WIDTH-1:0] out_data,
  output logic signed [OP_OUT_WIDTH-1:0] mod_prev,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           overrun,
  input  logic                           overrun_clr
);

  // Countdown for the extra cycles of an issued slot (SLOT_CYCLES-2 down to 0).
  localparam int WAIT_W = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES - 1) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic              vld;
    logic [BANK_W-1:0] bank;
    logic [OP_W-1:0]   op;
  } tag_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [NUM_SLOTS-1:0] r_skip;   // shifted once per slot: bit 0 always belongs to the current slot
  logic [BANK_W-1:0]    r_bank;
  logic [OP_W-1:0]      r_op;
  logic [WAIT_W-1:0]    r_wait;

  tag_t r_tag [PIPELINE_DELAY];

  logic                           r_out_valid;
  logic [BANK_W-1:0]              r_out_bank;
  logic [OP_W-1:0]                r_out_op;
  logic signed [OP_OUT_WIDTH-1:0] r_out_data;
  logic signed [OP_OUT_WIDTH-1:0] r_mod_prev;
  logic                           r_overrun;

  logic w_op_en;
  logic w_start;
  logic w_advance;
  logic w_wait_load;
  logic w_last_slot;
  logic w_pipe_busy;
  logic w_busy;

  assign w_last_slot = (r_bank == BANK_W'(NUM_BANKS - 1)) && (r_op == OP_W'(OPS_PER_BANK - 1));
  assign w_busy      = (r_state != ST_IDLE);

  // Any tag still in flight. Once this is clear in DRAIN, the last result has
  // already been loaded into (or has left) the output register, so the next
  // cycle is the first with nothing left to report.
  always_comb begin
    w_pipe_busy = 1'b0;
    for (int i = 0; i < PIPELINE_DELAY; i++) begin
      w_pipe_busy = w_pipe_busy | r_tag[i].vld;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_op_en     = 1'b0;
    w_start     = 1'b0;
    w_advance   = 1'b0;
    w_wait_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (sample_clk_en) begin
          w_start     = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (r_skip[0]) begin
          // Skipped slot costs exactly this one cycle.
          w_advance   = 1'b1;
          w_state_nxt = w_last_slot ? ST_DRAIN : ST_ISSUE;
        end else begin
          w_op_en = 1'b1;
          if (SLOT_CYCLES > 1) begin
            w_wait_load = 1'b1;
            w_state_nxt = ST_WAIT;
          end else begin
            w_advance   = 1'b1;
            w_state_nxt = w_last_slot ? ST_DRAIN : ST_ISSUE;
          end
        end
      end
      ST_WAIT: begin
        if (r_wait == '0) begin
          w_advance   = 1'b1;
          w_state_nxt = w_last_slot ? ST_DRAIN : ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (!w_pipe_busy) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Slot counters and latched skip mask
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_skip <= '0;
      r_bank <= '0;
      r_op   <= '0;
    end else if (w_start) begin
      r_skip <= skip_mask;
      r_bank <= '0;
      r_op   <= '0;
    end else if (w_advance) begin
      r_skip <= r_skip >> 1;
      // Coordinates stay on the final slot after the frame rather than wrapping
      // into a bank that may not exist.
      if (!w_last_slot) begin
        if (r_op == OP_W'(OPS_PER_BANK - 1)) begin
          r_op   <= '0;
          r_bank <= r_bank + 1'b1;
        end else begin
          r_op <= r_op + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait <= '0;
    end else if (w_wait_load) begin
      r_wait <= WAIT_W'(SLOT_CYCLES - 2);
    end else if ((r_state == ST_WAIT) && (r_wait != '0)) begin
      r_wait <= r_wait - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Tag pipeline: mirrors the operator core latency so the result arriving on
  // op_data_in can be labelled with the slot that produced it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PIPELINE_DELAY; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_tag[0].vld  <= w_op_en;
      r_tag[0].bank <= r_bank;
      r_tag[0].op   <= r_op;
      for (int i = 1; i < PIPELINE_DELAY; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  // Output register; data and mod_prev only move on a valid tap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_bank  <= '0;
      r_out_op    <= '0;
      r_out_data  <= '0;
      r_mod_prev  <= '0;
    end else if (r_tag[PIPELINE_DELAY-1].vld) begin
      r_out_valid <= 1'b1;
      r_out_bank  <= r_tag[PIPELINE_DELAY-1].bank;
      r_out_op    <= r_tag[PIPELINE_DELAY-1].op;
      r_out_data  <= op_data_in;
      r_mod_prev  <= op_data_in;
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky overrun; a new overrun in the same cycle as a clear must not be lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun <= 1'b0;
    end else if (sample_clk_en && w_busy) begin
      r_overrun <= 1'b1;
    end else if (overrun_clr) begin
      r_overrun <= 1'b0;
    end
  end

  assign op_en      = w_op_en;
  assign op_bank    = r_bank;
  assign op_num     = r_op;
  assign out_valid  = r_out_valid;
  assign out_bank   = r_out_bank;
  assign out_op     = r_out_op;
  assign out_data   = r_out_data;
  assign mod_prev   = r_mod_prev;
  assign busy       = w_busy;
  assign frame_done = (r_state == ST_DONE);
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_op_slot_sequencer.sv
// Purpose : randomized self-checking bench for op_slot_sequencer (default and small configurations).
// Latency : expectations are derived per frame from slot costs and the core delay.
// Backpressure: n/a.

module tb_op_slot_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default configuration: 2 banks x 18 ops, 2 cycles/slot, delay 6.
  logic        reset_n;
  logic        sample_clk_en;
  logic [35:0] skip_mask;
  logic        op_en;
  logic [0:0]  op_bank;
  logic [4:0]  op_num;
  logic [12:0] op_data_in;
  logic        out_valid;
  logic [0:0]  out_bank;
  logic [4:0]  out_op;
  logic [12:0] out_data;
  logic [12:0] mod_prev;
  logic        busy;
  logic        frame_done;
  logic        overrun;
  logic        overrun_clr;

  // Small configuration: 1 bank x 4 ops, 3 cycles/slot, delay 2.
  logic        sample_clk_en_s;
  logic [3:0]  skip_mask_s;
  logic        op_en_s;
  logic [0:0]  op_bank_s;
  logic [1:0]  op_num_s;
  logic [12:0] op_data_in_s;
  logic        out_valid_s;
  logic [0:0]  out_bank_s;
  logic [1:0]  out_op_s;
  logic [12:0] out_data_s;
  logic [12:0] mod_prev_s;
  logic        busy_s;
  logic        frame_done_s;
  logic        overrun_s;

  op_slot_sequencer dut (
    .clk(clk), .reset_n(reset_n), .sample_clk_en(sample_clk_en), .skip_mask(skip_mask),
    .op_en(op_en), .op_bank(op_bank), .op_num(op_num), .op_data_in(op_data_in),
    .out_valid(out_valid), .out_bank(out_bank), .out_op(out_op), .out_data(out_data),
    .mod_prev(mod_prev), .busy(busy), .frame_done(frame_done), .overrun(overrun),
    .overrun_clr(overrun_clr)
  );

  op_slot_sequencer #(
    .NUM_BANKS(1), .OPS_PER_BANK(4), .SLOT_CYCLES(3), .PIPELINE_DELAY(2), .OP_OUT_WIDTH(13)
  ) dut_s (
    .clk(clk), .reset_n(reset_n), .sample_clk_en(sample_clk_en_s), .skip_mask(skip_mask_s),
    .op_en(op_en_s), .op_bank(op_bank_s), .op_num(op_num_s), .op_data_in(op_data_in_s),
    .out_valid(out_valid_s), .out_bank(out_bank_s), .out_op(out_op_s), .out_data(out_data_s),
    .mod_prev(mod_prev_s), .busy(busy_s), .frame_done(frame_done_s), .overrun(overrun_s),
    .overrun_clr(1'b0)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [12:0] exp_mod  = '0;   // reference copy of the last captured result
  bit          exp_ov   = 1'b0; // reference copy of the sticky overrun flag

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", tag, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame of the default instance, starting from IDLE with the tick at offset 0.
  // tick2 / clr: offset of an extra tick / an overrun_clr pulse (-1 = none).
  task automatic run_frame(input logic [35:0] mask, input int tick2, input int clr);
    bit          e_en   [128];
    int          e_slot [128];
    bit          e_out  [128];
    int          e_oslot[128];
    logic [12:0] drv    [128];
    logic [63:0] rnd;
    int t, drain, last_out, fd;

    for (int k = 0; k < 128; k++) begin
      e_en[k]    = 1'b0;
      e_slot[k]  = 0;
      e_out[k]   = 1'b0;
      e_oslot[k] = 0;
      drv[k]     = 13'($urandom());
    end
    // Issued slots cost 2 cycles, skipped slots 1; the result appears 7 cycles after op_en.
    t = 1;
    last_out = -1;
    for (int i = 0; i < 36; i++) begin
      if (mask[i]) begin
        t = t + 1;
      end else begin
        e_en[t]      = 1'b1;
        e_slot[t]    = i;
        e_out[t+7]   = 1'b1;
        e_oslot[t+7] = i;
        last_out     = t + 7;
        if (i == 3) drv[t+6] = 13'h1FFB; // -5 for slot (0,3)
        t = t + 2;
      end
    end
    drain = t;
    fd    = ((last_out > drain) ? last_out : drain) + 1;
    if (tick2 > fd) tick2 = -1;

    for (int off = 0; off <= fd + 1; off++) begin
      chk("op_en", op_en, e_en[off]);
      if (e_en[off]) begin
        chk("op_bank", op_bank, e_slot[off] / 18);
        chk("op_num", op_num, e_slot[off] % 18);
      end
      chk("busy", busy, (off >= 1) && (off <= fd));
      chk("frame_done", frame_done, off == fd);
      chk("out_valid", out_valid, e_out[off]);
      if (e_out[off]) begin
        exp_mod = drv[off-1];
        chk("out_bank", out_bank, e_oslot[off] / 18);
        chk("out_op", out_op, e_oslot[off] % 18);
        chk("out_data", out_data, drv[off-1]);
      end
      chk("mod_prev", mod_prev, exp_mod);
      chk("overrun", overrun, exp_ov);

      sample_clk_en = (off == 0) || (off == tick2);
      overrun_clr   = (off == clr);
      op_data_in    = drv[off];
      if (off > 0) begin
        rnd = {$urandom(), $urandom()};
        skip_mask = rnd[35:0];   // mid-frame changes must be ignored
      end else begin
        skip_mask = mask;
      end
      if (sample_clk_en && (off >= 1) && (off <= fd)) exp_ov = 1'b1;
      else if (overrun_clr) exp_ov = 1'b0;
      step();
    end
    sample_clk_en = 1'b0;
    overrun_clr   = 1'b0;
  endtask

  initial begin
    logic [63:0] rnd;
    logic [35:0] m;
    logic [12:0] drv_s [20];

    reset_n = 1'b0;
    sample_clk_en = 1'b0; skip_mask = '0; op_data_in = '0; overrun_clr = 1'b0;
    sample_clk_en_s = 1'b0; skip_mask_s = '0; op_data_in_s = '0;
    step();
    step();
    chk("rst_op_en", op_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_mod_prev", mod_prev, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_op_num", op_num, 0);
    reset_n = 1'b1;
    step();

    // Full frame with an overrun tick at cycle 20.
    run_frame(36'h0, 20, -1);
    // Only slot (1,17) issued; tick and clear together while busy: set wins.
    run_frame(36'hF_FFFF_FFFF ^ (36'd1 << 35), 15, 15);
    // overrun_clr alone.
    overrun_clr = 1'b1;
    exp_ov = 1'b0;
    step();
    overrun_clr = 1'b0;
    chk("ovr_clr", overrun, 0);
    // Every slot skipped.
    run_frame(36'hF_FFFF_FFFF, -1, -1);

    // Random masks of varying density, random extra ticks and clears.
    for (int f = 0; f < 8; f++) begin
      rnd = {$urandom(), $urandom()};
      case (f % 3)
        0: m = rnd[35:0];
        1: m = rnd[35:0] & 36'($urandom());
        default: m = rnd[35:0] | 36'($urandom());
      endcase
      run_frame(m, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 60)) : -1,
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 60)) : -1);
    end

    // Reset in the middle of a frame.
    skip_mask = '0;
    sample_clk_en = 1'b1;
    step();
    sample_clk_en = 1'b0;
    for (int k = 1; k < 30; k++) step();
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_out_valid", out_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_op_num", op_num, 0);
    chk("mid_rst_mod_prev", mod_prev, 0);
    chk("mid_rst_overrun", overrun, 0);
    step();
    step();
    reset_n = 1'b1;
    exp_mod = '0;
    exp_ov  = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("post_rst_frame_done", frame_done, 0);
      chk("post_rst_busy", busy, 0);
    end
    run_frame(36'h0, -1, -1);

    // Small configuration: op_en at 1,4,7,10; out_valid at 4,7,10,13; frame_done at 14.
    for (int k = 0; k < 20; k++) drv_s[k] = 13'($urandom());
    for (int off = 0; off <= 16; off++) begin
      chk("s_op_en", op_en_s, (off >= 1) && (off <= 10) && ((off - 1) % 3 == 0));
      if ((off >= 1) && (off <= 10) && ((off - 1) % 3 == 0)) begin
        chk("s_op_num", op_num_s, (off - 1) / 3);
      end
      chk("s_out_valid", out_valid_s, (off >= 4) && (off <= 13) && ((off - 1) % 3 == 0));
      if ((off >= 4) && (off <= 13) && ((off - 1) % 3 == 0)) begin
        chk("s_out_op", out_op_s, (off - 4) / 3);
        chk("s_out_data", out_data_s, drv_s[off-1]);
      end
      chk("s_frame_done", frame_done_s, off == 14);
      chk("s_busy", busy_s, (off >= 1) && (off <= 14));
      sample_clk_en_s = (off == 0);
      op_data_in_s    = drv_s[off];
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
